serial_bus_arbiter: RTL and testbench
=====================================

Name: serial_bus_arbiter

Overview:
Shares one bit-serial slave port between NUM_MASTERS requesters.
- Grants bus ownership to one master for a whole transaction: address, then write data or read data.
- While a master owns the bus, its serial signals are muxed to the slave and the slave's responses are routed back to it.
- Sits between the master ports and a slave port. It tracks transaction length by counting handshake beats, then releases the bus.

Parameters:
NUM_MASTERS, 2, number of requesting masters (2..8)
ADDR_WIDTH, 16, address bits per transaction, sent MSB first
DATA_WIDTH, 8, data bits per transaction
TIMEOUT, 64, idle cycles without a beat before forced release (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-high
m_req  in  NUM_MASTERS  per-master bus request, held for the whole transaction
m_mode  in  NUM_MASTERS  per-master mode (1=write, 0=read), sampled at grant
m_wr_bus  in  NUM_MASTERS  per-master serial write bit
m_valid  in  NUM_MASTERS  per-master master_valid
m_ready  in  NUM_MASTERS  per-master master_ready
m_grant  out  NUM_MASTERS  one-hot ownership, registered
m_rd_bus  out  NUM_MASTERS  slave rd_bus, routed to owner only, others 0
m_slave_ready  out  NUM_MASTERS  slave_ready, routed to owner only
m_slave_valid  out  NUM_MASTERS  slave_valid, routed to owner only
s_mode  out  1  to slave mode
s_wr_bus  out  1  to slave wr_bus
s_master_valid  out  1  to slave master_valid
s_master_ready  out  1  to slave master_ready
s_rd_bus  in  1  from slave rd_bus
s_slave_ready  in  1  from slave slave_ready
s_slave_valid  in  1  from slave slave_valid
busy  out  1  high while any grant is active
timeout  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (rst=1 at clk edge): state=IDLE, m_grant=0, busy=0, timeout=0, rr_ptr=0, beat counter=0, idle counter=0. Reset mid-transaction drops the grant on the next edge, with no release cycle.
- While no grant is active, all s_* outputs are 0.
- Routing is combinational from the registered owner index. s_* = owner's m_* bits. m_rd_bus, m_slave_ready and m_slave_valid show the s_* inputs at the owner's bit position and are 0 elsewhere.
- Arbitration is round-robin. The winner is the first asserted m_req scanning from rr_ptr upward, modulo NUM_MASTERS. On grant, rr_ptr = winner+1 mod NUM_MASTERS.
- States:
  - IDLE: if any m_req, register the winner and its m_mode, set m_grant[winner], go to ADDR. Grant latency is one cycle after m_req is sampled.
  - ADDR: a beat is s_master_valid & s_slave_ready. After the ADDR_WIDTH-th beat, go to WDATA if latched mode=1, else RDATA. Clear the beat counter.
  - WDATA: same beat definition. After the DATA_WIDTH-th beat, go to RELEASE.
  - RDATA: a beat is s_slave_valid & s_master_ready. After the DATA_WIDTH-th beat, go to RELEASE.
  - RELEASE: m_grant=0 for exactly one cycle, then IDLE. This gives the slave time to return to idle.
- Abort: if the owner's m_req=0 in ADDR, WDATA or RDATA, go to RELEASE next cycle and leave timeout at 0.
- Timeout:
  - The idle counter increments each cycle in ADDR, WDATA or RDATA with no beat, and resets to 0 on any beat.
  - When it reaches TIMEOUT-1 with no beat, go to RELEASE and pulse timeout for one cycle, coincident with the RELEASE state.
- Priority when events coincide in the same cycle: abort > final beat > timeout. A final beat with timeout still counts as a beat (timeout=0).
- The beat counter is $clog2(ADDR_WIDTH+DATA_WIDTH+1) bits wide. It never wraps, because transitions fire on the exact count.
- Requests from non-owners are ignored until RELEASE has finished.
- Changes to m_mode after grant are ignored.
- busy = |m_grant.

Test Plan:
- Single write: master0 raises req with mode=1 and streams 16 address beats then 8 data beats → grant[0] asserts 1 cycle after req, RELEASE after beat 24, grant=0 for 1 cycle, busy falls.
- Contention: m_req=2'b11 from reset → master0 granted first. Master1 granted in the cycle after IDLE is re-entered (2 cycles after master0's grant drops). rr_ptr then =0.
- Read routing: master1 reads; slave returns 8 valid bits 0xA5 with m_ready[1]=1 → m_rd_bus[1] carries 1,0,1,0,0,1,0,1 and m_rd_bus[0] stays 0. Release after the 8th beat.
- Abort: master0 drops req after 5 address beats → RELEASE next cycle, timeout=0, master1 (requesting) granted 2 cycles later.
- Timeout: TIMEOUT=4, owner holds req but m_valid=0 → timeout pulses 4 cycles after the last beat and the grant drops.
- Reset mid-WDATA: rst=1 for 1 cycle → grant=0, busy=0, and all s_* outputs 0 on the next edge.

Source files
------------

// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: round-robin arbiter sharing one bit-serial slave port among masters
module serial_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_MASTERS-1:0] m_req,
  input  logic [NUM_MASTERS-1:0] m_mode,
  input  logic [NUM_MASTERS-1:0] m_wr_bus,
  input  logic [NUM_MASTERS-1:0] m_valid,
  input  logic [NUM_MASTERS-1:0] m_ready,
  output logic [NUM_MASTERS-1:0] m_grant,
  output logic [NUM_MASTERS-1:0] m_rd_bus,
  output logic [NUM_MASTERS-1:0] m_slave_ready,
  output logic [NUM_MASTERS-1:0] m_slave_valid,
  output logic                   s_mode,
  output logic                   s_wr_bus,
  output logic                   s_master_valid,
  output logic                   s_master_ready,
  input  logic                   s_rd_bus,
  input  logic                   s_slave_ready,
  input  logic                   s_slave_valid,
  output logic                   busy,
  output logic                   timeout
);
  localparam int IW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = $clog2(ADDR_WIDTH + DATA_WIDTH + 1);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RDATA, REL} state_t;
  state_t state, state_n;
  logic [IW-1:0] owner, rr_ptr, win, k;
  logic [CW-1:0] cnt;
  logic [TW-1:0] idle;
  logic found, mode_q, xfer, beat, last, abort, expire;
  assign busy = |m_grant;
  assign xfer = state inside {ADDR, WDATA, RDATA};
  assign beat = (state == RDATA) ? (s_slave_valid & s_master_ready) : (s_master_valid & s_slave_ready);
  assign last = beat & (cnt == (state == ADDR ? CW'(ADDR_WIDTH - 1) : CW'(DATA_WIDTH - 1)));
  assign abort = !m_req[owner];
  assign expire = !beat & (idle == TW'(TIMEOUT - 1));
  // first requester at or after rr_ptr, wrapping around
  always_comb begin
    win = '0;
    found = 1'b0;
    k = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      k = IW'((int'(rr_ptr) + i) % NUM_MASTERS);
      if (!found && m_req[k]) begin
        win = k;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      m_grant <= '0;
      timeout <= 1'b0;
      rr_ptr <= '0;
      owner <= '0;
      mode_q <= 1'b0;
      cnt <= '0;
      idle <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && found) begin
        owner <= win;
        mode_q <= m_mode[win];
        rr_ptr <= (win == IW'(NUM_MASTERS - 1)) ? '0 : win + 1'b1;
      end
      m_grant <= (state_n inside {ADDR, WDATA, RDATA}) ? NUM_MASTERS'(1) << (state == IDLE ? win : owner) : '0;
      timeout <= xfer & !abort & expire;
      cnt <= (!xfer || last) ? '0 : cnt + CW'(beat);
      idle <= (!xfer || beat) ? '0 : idle + TW'(1);
    end
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = found ? ADDR : IDLE;
      ADDR, WDATA, RDATA:
        state_n = abort ? REL : last ? (state == ADDR ? (mode_q ? WDATA : RDATA) : REL) : expire ? REL : state;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    s_mode = busy & mode_q;
    s_wr_bus = busy & m_wr_bus[owner];
    s_master_valid = busy & m_valid[owner];
    s_master_ready = busy & m_ready[owner];
    m_rd_bus = busy ? NUM_MASTERS'(s_rd_bus) << owner : '0;
    m_slave_ready = busy ? NUM_MASTERS'(s_slave_ready) << owner : '0;
    m_slave_valid = busy ? NUM_MASTERS'(s_slave_valid) << owner : '0;
  end
endmodule

// File: tb/tb_serial_bus_arbiter.sv
// tb_serial_bus_arbiter: random traffic against a beat-counting transaction model
module tb_serial_bus_arbiter;
  localparam int N = 3;
  localparam int AW = 16;
  localparam int DW = 8;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst;
  logic [N-1:0] m_req, m_mode, m_wr_bus, m_valid, m_ready;
  logic [N-1:0] m_grant, m_rd_bus, m_slave_ready, m_slave_valid;
  logic s_mode, s_wr_bus, s_master_valid, s_master_ready;
  logic s_rd_bus, s_slave_ready, s_slave_valid, busy, timeout;
  int n_chk = 0;
  int n_fail = 0;
  int own, done, idl, rr, p;
  bit mode, rel, tmo, rd, b;
  always #5 clk = ~clk;
  serial_bus_arbiter #(.NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_mode(m_mode), .m_wr_bus(m_wr_bus),
    .m_valid(m_valid), .m_ready(m_ready), .m_grant(m_grant), .m_rd_bus(m_rd_bus),
    .m_slave_ready(m_slave_ready), .m_slave_valid(m_slave_valid), .s_mode(s_mode),
    .s_wr_bus(s_wr_bus), .s_master_valid(s_master_valid), .s_master_ready(s_master_ready),
    .s_rd_bus(s_rd_bus), .s_slave_ready(s_slave_ready), .s_slave_valid(s_slave_valid),
    .busy(busy), .timeout(timeout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit rb(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction
  initial begin
    rst = 1'b1;
    {m_req, m_mode, m_wr_bus, m_valid, m_ready} = '0;
    {s_rd_bus, s_slave_ready, s_slave_valid} = '0;
    own = -1; done = 0; idl = 0; rr = 0; mode = 0; rel = 0; tmo = 0; p = 90;
    repeat (2) @(posedge clk);
    #1;
    for (int c = 0; c < 6000; c++) begin
      if (c % 150 == 0) p = ($urandom_range(2) == 0) ? 20 : ($urandom_range(1) == 0) ? 60 : 95;
      rst = ($urandom_range(399) == 0);
      for (int i = 0; i < N; i++) begin
        m_req[i] = m_req[i] ? ($urandom_range(59) != 0) : ($urandom_range(7) == 0);
        m_mode[i] = rb(50);
        m_wr_bus[i] = rb(50);
        m_valid[i] = rb(p);
        m_ready[i] = rb(p);
      end
      s_rd_bus = rb(50);
      s_slave_ready = rb(p);
      s_slave_valid = rb(p);
      #2;
      chk("grant", m_grant, own >= 0 ? N'(1) << own : '0);
      chk("busy", busy, own >= 0);
      chk("timeout", timeout, tmo);
      chk("s_bus", {s_mode, s_wr_bus, s_master_valid, s_master_ready},
          own >= 0 ? {mode, m_wr_bus[own], m_valid[own], m_ready[own]} : 4'b0);
      chk("rd_bus", m_rd_bus, own >= 0 ? N'(s_rd_bus) << own : '0);
      chk("slave_ready", m_slave_ready, own >= 0 ? N'(s_slave_ready) << own : '0);
      chk("slave_valid", m_slave_valid, own >= 0 ? N'(s_slave_valid) << own : '0);
      @(posedge clk);
      if (rst) begin
        own = -1; rel = 0; tmo = 0; rr = 0; done = 0; idl = 0;
      end else if (rel) begin
        rel = 0; tmo = 0;
      end else if (own < 0) begin
        tmo = 0;
        for (int i = 0; i < N; i++)
          if (own < 0 && m_req[(rr + i) % N]) own = (rr + i) % N;
        if (own >= 0) begin
          mode = m_mode[own]; rr = (own + 1) % N; done = 0; idl = 0;
        end
      end else begin
        tmo = 0;
        rd = (done >= AW) && !mode;
        b = rd ? (s_slave_valid & m_ready[own]) : (m_valid[own] & s_slave_ready);
        if (!m_req[own]) begin
          own = -1; rel = 1;
        end else if (b) begin
          done++; idl = 0;
          if (done == AW + DW) begin own = -1; rel = 1; end
        end else if (idl == TO - 1) begin
          own = -1; rel = 1; tmo = 1;
        end else idl++;
      end
      #1;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
